// File: rtl/matrix_alu_2x2_seq.sv
// Sequential 2x2 matrix ALU: add, subtract, multiply, transpose and determinant
// behind a start/ready/busy/done handshake, with one shared DW x DW multiplier.
module matrix_alu_2x2_seq #(
    parameter int unsigned DW = 4,
    parameter int unsigned OW = 2*DW+2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [4*DW-1:0] a,
    input  logic [4*DW-1:0] b,
    output logic            ready,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [4*OW-1:0] c,
    output logic [OW-1:0]   det
);

    localparam int unsigned PW = 2*DW;
    localparam int unsigned SW = 2*DW+1;
    localparam int unsigned CW = 3;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_TRN = 3'd3;
    localparam logic [2:0] OP_DET = 3'd4;

    generate
        if (OW < 2*DW+2) begin : g_bad_ow
            $error("matrix_alu_2x2_seq: OW must be >= 2*DW+2");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_DONE
    } state_t;

    state_t          state;
    logic [4*DW-1:0] a_q;
    logic [4*DW-1:0] b_q;
    logic [2:0]      op_q;
    logic [CW-1:0]   cnt;
    logic [PW-1:0]   acc_q;
    logic [SW-1:0]   res_q [3];

    logic [DW-1:0]   mul_x_c;
    logic [DW-1:0]   mul_y_c;
    logic [PW-1:0]   prod_c;
    logic [SW-1:0]   sum_c;
    logic [OW-1:0]   det_c;
    logic [4*OW-1:0] add_c;
    logic [4*OW-1:0] sub_c;
    logic [4*OW-1:0] trn_c;
    logic [4*OW-1:0] mul_c;
    logic            last_step_c;
    logic            op_legal_c;

    // Element k of a packed matrix: 0=e11, 1=e12, 2=e21, 3=e22.
    function automatic logic [DW-1:0] el(input logic [4*DW-1:0] m, input logic [1:0] k);
        case (k)
            2'd0:    el = m[4*DW-1 -: DW];
            2'd1:    el = m[3*DW-1 -: DW];
            2'd2:    el = m[2*DW-1 -: DW];
            default: el = m[DW-1:0];
        endcase
    endfunction

    // Multiplier operand select: MUL walks row(cnt[2]) x col(cnt[1]), k = cnt[0].
    always_comb begin
        mul_x_c = el(a_q, {cnt[2], cnt[0]});
        mul_y_c = el(b_q, {cnt[0], cnt[1]});
        if (op_q == OP_DET) begin
            mul_x_c = el(a_q, cnt[0] ? 2'd1 : 2'd0);
            mul_y_c = el(a_q, cnt[0] ? 2'd2 : 2'd3);
        end
    end

    assign prod_c = {{DW{1'b0}}, mul_x_c} * {{DW{1'b0}}, mul_y_c};
    assign sum_c  = {1'b0, acc_q} + {1'b0, prod_c};
    assign det_c  = OW'(acc_q) - OW'(prod_c);

    // Single-step element-wise results.
    always_comb begin
        add_c = '0;
        sub_c = '0;
        for (int k = 0; k < 4; k++) begin
            add_c[(3-k)*OW +: OW] = OW'(el(a_q, 2'(k))) + OW'(el(b_q, 2'(k)));
            sub_c[(3-k)*OW +: OW] = OW'($signed({1'b0, el(a_q, 2'(k))} - {1'b0, el(b_q, 2'(k))}));
        end
    end

    assign trn_c = {OW'(el(a_q, 2'd0)), OW'(el(a_q, 2'd2)), OW'(el(a_q, 2'd1)), OW'(el(a_q, 2'd3))};
    assign mul_c = {OW'(res_q[0]), OW'(res_q[1]), OW'(res_q[2]), OW'(sum_c)};

    always_comb begin
        case (op_q)
            OP_MUL:  last_step_c = (cnt == CW'(7));
            OP_DET:  last_step_c = (cnt == CW'(1));
            default: last_step_c = 1'b1;
        endcase
    end

    assign op_legal_c = (op <= OP_DET);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            cnt      <= '0;
            acc_q    <= '0;
            res_q[0] <= '0;
            res_q[1] <= '0;
            res_q[2] <= '0;
            ready    <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            c        <= '0;
            det      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        ready <= 1'b0;
                        if (op_legal_c) begin
                            a_q   <= a;
                            b_q   <= b;
                            op_q  <= op;
                            cnt   <= '0;
                            err   <= 1'b0;
                            busy  <= 1'b1;
                            state <= S_EXEC;
                        end else begin
                            err   <= 1'b1;
                            c     <= '0;
                            det   <= '0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end
                end
                S_EXEC: begin
                    cnt <= cnt + CW'(1);
                    case (op_q)
                        OP_ADD: begin
                            c   <= add_c;
                            det <= '0;
                        end
                        OP_SUB: begin
                            c   <= sub_c;
                            det <= '0;
                        end
                        OP_TRN: begin
                            c   <= trn_c;
                            det <= '0;
                        end
                        // Even steps hold the first product, odd steps finish an element.
                        OP_MUL: begin
                            if (!cnt[0]) begin
                                acc_q <= prod_c;
                            end else if (!last_step_c) begin
                                res_q[cnt[2:1]] <= sum_c;
                            end else begin
                                c   <= mul_c;
                                det <= '0;
                            end
                        end
                        OP_DET: begin
                            if (!cnt[0]) begin
                                acc_q <= prod_c;
                            end else begin
                                det <= det_c;
                                c   <= '0;
                            end
                        end
                        default: begin
                            c   <= '0;
                            det <= '0;
                        end
                    endcase
                    if (last_step_c) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    ready <= 1'b1;
                    state <= S_IDLE;
                end
                default: begin
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
